wisc_pipe_ctrl: RTL

- Pipelined successor to the single-cycle opcode decoder for the 16-bit WISC core.
- Decodes the 4-bit opcode in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles; signals branch flush.
- Latches a sticky halt when HLT retires.

---
 rtl/wisc_pipe_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wisc_pipe_ctrl.sv
// Pipelined control for the 16-bit WISC core: decodes the opcode in ID and carries controls through EX/MEM/WB.
// Handles load-use stalls, branch flush and a sticky halt.
module wisc_pipe_ctrl #(
    parameter int RA_W         = 4,
    parameter int R0_HARDWIRED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [3:0]      id_opcode,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            branch_taken,
    output logic            stall,
    output logic            flush,
    output logic            pc_hold,
    output logic            ex_alusrc,
    output logic            ex_pcs,
    output logic            ex_loadbyte,
    output logic [RA_W-1:0] ex_rd,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic [RA_W-1:0] mem_rd,
    output logic            mem_regwrite,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [RA_W-1:0] wb_rd,
    output logic            halted
);

    logic d_alusrc, d_pcs, d_loadbyte, d_memread, d_memwrite, d_regwrite, d_memtoreg, d_halt, d_branch;
    logic uses_rs, uses_rt;

    logic            ex_alusrc_reg, ex_pcs_reg, ex_loadbyte_reg, ex_memread_reg;
    logic            ex_memwrite_reg, ex_regwrite_reg, ex_memtoreg_reg, ex_halt_reg;
    logic [RA_W-1:0] ex_rd_reg;
    logic            mem_memread_reg, mem_memwrite_reg, mem_regwrite_reg, mem_memtoreg_reg, mem_halt_reg;
    logic [RA_W-1:0] mem_rd_reg;
    logic            wb_regwrite_reg, wb_memtoreg_reg;
    logic [RA_W-1:0] wb_rd_reg;
    logic            pc_hold_reg, halted_reg;

    logic rd_can_hazard, bubble;

    always_comb begin
        d_alusrc   = 1'b0;
        d_pcs      = 1'b0;
        d_loadbyte = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_halt     = 1'b0;
        d_branch   = 1'b0;
        case (id_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: d_regwrite = 1'b1;
            4'b0100, 4'b0101, 4'b0110: begin
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
            end
            4'b1000: begin
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
            end
            4'b1001: begin
                d_alusrc   = 1'b1;
                d_memwrite = 1'b1;
            end
            4'b1010, 4'b1011: begin
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
                d_loadbyte = 1'b1;
            end
            4'b1100, 4'b1101: d_branch = 1'b1;
            4'b1110: begin
                d_pcs      = 1'b1;
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
            end
            default: d_halt = 1'b1;
        endcase
    end

    always_comb begin
        uses_rt = 1'b0;
        uses_rs = 1'b1;
        case (id_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001: uses_rt = 1'b1;
            default: uses_rt = 1'b0;
        endcase
        if (id_opcode == 4'b1100 || id_opcode == 4'b1110 || id_opcode == 4'b1111)
            uses_rs = 1'b0;
    end

    // A load into r0 cannot create a dependency when r0 is wired to zero.
    assign rd_can_hazard = (ex_rd_reg != '0) || (R0_HARDWIRED == 0);
    assign stall = id_valid & ex_memread_reg & rd_can_hazard &
                   ((uses_rs & (ex_rd_reg == id_rs)) | (uses_rt & (ex_rd_reg == id_rt)));
    assign flush  = branch_taken & id_valid & ~stall & ~pc_hold_reg;
    assign bubble = stall | ~id_valid | pc_hold_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_alusrc_reg    <= 1'b0;
            ex_pcs_reg       <= 1'b0;
            ex_loadbyte_reg  <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_memwrite_reg  <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_memtoreg_reg  <= 1'b0;
            ex_halt_reg      <= 1'b0;
            ex_rd_reg        <= '0;
            mem_memread_reg  <= 1'b0;
            mem_memwrite_reg <= 1'b0;
            mem_regwrite_reg <= 1'b0;
            mem_memtoreg_reg <= 1'b0;
            mem_halt_reg     <= 1'b0;
            mem_rd_reg       <= '0;
            wb_regwrite_reg  <= 1'b0;
            wb_memtoreg_reg  <= 1'b0;
            wb_rd_reg        <= '0;
            pc_hold_reg      <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            ex_alusrc_reg    <= ~bubble & d_alusrc;
            ex_pcs_reg       <= ~bubble & d_pcs;
            ex_loadbyte_reg  <= ~bubble & d_loadbyte;
            ex_memread_reg   <= ~bubble & d_memread;
            ex_memwrite_reg  <= ~bubble & d_memwrite;
            ex_regwrite_reg  <= ~bubble & d_regwrite;
            ex_memtoreg_reg  <= ~bubble & d_memtoreg;
            ex_halt_reg      <= ~bubble & d_halt;
            // Branches carry no controls, so they travel on as a plain bubble.
            ex_rd_reg        <= (bubble | d_branch) ? '0 : id_rd;
            mem_memread_reg  <= ex_memread_reg;
            mem_memwrite_reg <= ex_memwrite_reg;
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_memtoreg_reg <= ex_memtoreg_reg;
            mem_halt_reg     <= ex_halt_reg;
            mem_rd_reg       <= ex_rd_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_memtoreg_reg  <= mem_memtoreg_reg;
            wb_rd_reg        <= mem_rd_reg;
            pc_hold_reg      <= pc_hold_reg | (~bubble & d_halt);
            halted_reg       <= halted_reg | mem_halt_reg;
        end
    end

    assign pc_hold      = pc_hold_reg;
    assign ex_alusrc    = ex_alusrc_reg;
    assign ex_pcs       = ex_pcs_reg;
    assign ex_loadbyte  = ex_loadbyte_reg;
    assign ex_rd        = ex_rd_reg;
    assign mem_memread  = mem_memread_reg;
    assign mem_memwrite = mem_memwrite_reg;
    assign mem_rd       = mem_rd_reg;
    assign mem_regwrite = mem_regwrite_reg;
    assign wb_regwrite  = wb_regwrite_reg;
    assign wb_memtoreg  = wb_memtoreg_reg;
    assign wb_rd        = wb_rd_reg;
    assign halted       = halted_reg;

endmodule
